// File: rtl/key_debounce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce_pkg : shared state encoding and defaults for key debouncing   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package key_debounce_pkg;

  // Bit 1 of the state is the debounced "pressed" level.
  typedef logic [1:0] state_t;

  localparam state_t c_ST_UP        = 2'b00;
  localparam state_t c_ST_WAIT_DOWN = 2'b01;
  localparam state_t c_ST_DOWN      = 2'b10;
  localparam state_t c_ST_WAIT_UP   = 2'b11;

  localparam int c_DEBOUNCE_CYCLES_DEFAULT = 500000;

  function automatic int eff_cycles(input int cycles);
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_cell : one pushbutton channel (sync, FSM, counter, pulses)        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle
);

  localparam int              c_EFF = eff_cycles(DEBOUNCE_CYCLES);
  localparam int              c_CW  = $clog2(c_EFF + 1);
  localparam logic [c_CW-1:0] c_MAX = c_CW'(c_EFF);

  logic            r_sync1;
  logic            r_sync2;
  state_t          r_state;
  logic [c_CW-1:0] r_count;
  logic            r_press;
  logic            r_release;
  logic            r_toggle;

  state_t          w_state_nxt;
  logic [c_CW-1:0] w_count_nxt;
  logic            w_press;
  logic            w_release;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      c_ST_UP: begin
        if (!r_sync2) begin
          w_state_nxt = c_ST_WAIT_DOWN;
          w_count_nxt = c_CW'(1);
        end else begin
          w_count_nxt = '0;
        end
      end
      c_ST_WAIT_DOWN: begin
        if (r_sync2) begin
          w_state_nxt = c_ST_UP;
          w_count_nxt = '0;
        end else if (r_count < c_MAX) begin
          w_count_nxt = r_count + 1'b1;
        end else begin
          w_state_nxt = c_ST_DOWN;
          w_count_nxt = '0;
        end
      end
      c_ST_DOWN: begin
        if (r_sync2) begin
          w_state_nxt = c_ST_WAIT_UP;
          w_count_nxt = c_CW'(1);
        end else begin
          w_count_nxt = '0;
        end
      end
      default: begin
        if (!r_sync2) begin
          w_state_nxt = c_ST_DOWN;
          w_count_nxt = '0;
        end else if (r_count < c_MAX) begin
          w_count_nxt = r_count + 1'b1;
        end else begin
          w_state_nxt = c_ST_UP;
          w_count_nxt = '0;
        end
      end
    endcase
  end

  assign w_press   = (r_state == c_ST_WAIT_DOWN) && (w_state_nxt == c_ST_DOWN);
  assign w_release = (r_state == c_ST_WAIT_UP)   && (w_state_nxt == c_ST_UP);

  // Synchronizer resets to "released" so a held key is re-qualified after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= c_ST_UP;
      r_count   <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_sync1   <= key_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_toggle  <= r_toggle ^ w_press;
    end
  end

  assign key_level   = r_state[1];
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_toggle  = r_toggle;

endmodule
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_debounce : NUM_KEYS independent active-low pushbutton debouncers       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .key_n      (key_n[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_toggle (key_toggle[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_debounce : directed bench with run-length behavioural model         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_key_debounce;

  localparam int c_D = 4;
  localparam int c_N = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [c_N-1:0] key_n = '1;
  logic [c_N-1:0] key_level, key_press, key_release, key_toggle;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce #(
    .NUM_KEYS       (c_N),
    .DEBOUNCE_CYCLES(c_D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle)
  );

  always #5 clk = ~clk;

  // Model: a change is accepted once the synchronized key has disagreed with
  // the debounced level on D+1 consecutive clock samples.
  logic [c_N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_tog;
  int             m_run [c_N];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_rel = '0; m_tog = '0;
      for (int i = 0; i < c_N; i++) m_run[i] = 0;
    end else begin
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < c_N; i++) begin
        if (!m_s2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == c_D + 1) begin
            m_run[i]   = 0;
            m_level[i] = ~m_level[i];
            if (m_level[i]) begin
              m_press[i] = 1'b1;
              m_tog[i]   = ~m_tog[i];
            end else begin
              m_rel[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = key_n;
    end
  end

  task automatic chk(input string name, input logic [c_N-1:0] act, input logic [c_N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every cycle: advance to the sampling edge and compare DUT with the model.
  task automatic tick();
    @(negedge clk);
    n_cmp++;
    if ({key_level, key_press, key_release, key_toggle} !== {m_level, m_press, m_rel, m_tog}) begin
      n_err++;
      $display("FAIL model: lvl/prs/rel/tog got %b/%b/%b/%b expected %b/%b/%b/%b at %0t",
               key_level, key_press, key_release, key_toggle,
               m_level, m_press, m_rel, m_tog, $time);
    end
  endtask

  int presses;
  int drops;

  initial begin
    repeat (3) tick();
    chk("rst_level", key_level, 2'b00);
    chk("rst_press", key_press, 2'b00);
    chk("rst_release", key_release, 2'b00);
    chk("rst_toggle", key_toggle, 2'b00);
    reset = 1'b0;
    repeat (3) tick();

    // Clean press of key 0
    key_n[0] = 1'b0;
    repeat (6) tick();
    chk("press_e6_press", key_press, 2'b00);
    chk("press_e6_level", key_level, 2'b00);
    tick();
    chk("press_e7_press", key_press, 2'b01);
    chk("press_e7_level", key_level, 2'b01);
    chk("press_e7_toggle", key_toggle, 2'b01);
    tick();
    chk("press_e8_press", key_press, 2'b00);
    chk("press_e8_level", key_level, 2'b01);
    repeat (5) tick();

    // Release of key 0
    key_n[0] = 1'b1;
    repeat (7) tick();
    chk("rel_e7_release", key_release, 2'b01);
    chk("rel_e7_level", key_level, 2'b00);
    chk("rel_e7_toggle", key_toggle, 2'b01);
    tick();
    chk("rel_e8_release", key_release, 2'b00);
    repeat (3) tick();

    // Bounce: low 3, high 1, then steady low
    key_n[0] = 1'b0;
    repeat (3) tick();
    key_n[0] = 1'b1;
    tick();
    key_n[0] = 1'b0;
    repeat (6) tick();
    chk("bounce_e6_press", key_press, 2'b00);
    chk("bounce_e6_level", key_level, 2'b00);
    tick();
    chk("bounce_e7_press", key_press, 2'b01);
    chk("bounce_e7_toggle", key_toggle, 2'b00);
    repeat (3) tick();
    key_n = 2'b11;
    repeat (10) tick();

    // Simultaneous press of both keys, then key 1 alone
    key_n = 2'b00;
    repeat (7) tick();
    chk("simul_press", key_press, 2'b11);
    chk("simul_toggle", key_toggle, 2'b11);
    chk("simul_level", key_level, 2'b11);
    key_n = 2'b11;
    repeat (10) tick();
    chk("simul_released", key_level, 2'b00);
    key_n = 2'b01;
    repeat (7) tick();
    chk("key1_press", key_press, 2'b10);
    chk("key1_toggle", key_toggle, 2'b01);
    key_n = 2'b11;
    repeat (10) tick();

    // Reset while key 0 is mid-debounce (count=2)
    key_n[0] = 1'b0;
    repeat (4) tick();
    chk("mid_level", key_level, 2'b00);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_level", key_level, 2'b00);
    chk("async_rst_toggle", key_toggle, 2'b00);
    chk("async_rst_press", key_press, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("after_rst_e6_press", key_press, 2'b00);
    tick();
    chk("after_rst_e7_press", key_press, 2'b01);
    chk("after_rst_e7_toggle", key_toggle, 2'b01);
    key_n = 2'b11;
    repeat (10) tick();

    // Long hold: exactly one press, level never drops once accepted
    presses = 0;
    drops   = 0;
    key_n[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (key_press[0]) presses++;
      if (i >= 6 && !key_level[0]) drops++;
    end
    chk_int("hold_presses", presses, 1);
    chk_int("hold_level_drops", drops, 0);
    chk("hold_toggle", key_toggle, 2'b00);
    key_n = 2'b11;
    repeat (10) tick();
    chk("final_level", key_level, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 2, giving the number of independent pushbutton channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-sample count needed to accept a change (10 ms at 50 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port key_n, input, NUM_KEYS bits: raw pushbuttons, active-low, asynchronous to clk.
REQ-006 The block SHALL have port key_level, output, NUM_KEYS bits: debounced state, 1 = pressed.
REQ-007 The block SHALL have port key_press, output, NUM_KEYS bits: one-cycle pulse on an accepted press.
REQ-008 The block SHALL have port key_release, output, NUM_KEYS bits: one-cycle pulse on an accepted release.
REQ-009 The block SHALL have port key_toggle, output, NUM_KEYS bits: state that inverts on each accepted press.

Function
REQ-010 Each channel SHALL pass key_n[i] through a two-flop synchronizer; later logic SHALL use only the second flop, sync[i].
REQ-011 Each channel SHALL run an independent FSM with states UP, WAIT_DOWN, DOWN and WAIT_UP, plus a saturating counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-012 UP: sync=0 -> WAIT_DOWN with count=1; otherwise the FSM SHALL hold with count=0.
REQ-013 WAIT_DOWN: sync=1 -> UP with count=0 (bounce rejected); sync=0 and count<DEBOUNCE_CYCLES -> count+1; sync=0 and count=DEBOUNCE_CYCLES -> DOWN with count=0.
REQ-014 DOWN and WAIT_UP SHALL mirror REQ-012/013 with sync polarity inverted: DOWN -> WAIT_UP -> UP, and a bounce returns the FSM to DOWN.
REQ-015 key_level[i] SHALL be 1 exactly when the FSM is in DOWN or WAIT_UP, and SHALL be registered.
REQ-016 On the DOWN entry edge, key_press[i] SHALL be 1 for exactly one cycle; on the UP entry edge from WAIT_UP, key_release[i] SHALL be 1 for exactly one cycle.
REQ-017 key_toggle[i] SHALL invert on the same edge that asserts key_press[i], and SHALL be unaffected by release.
REQ-018 Latency: with key_n stable low, key_level SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples key_n low; release latency SHALL be symmetric.
REQ-019 key_press and key_release for one channel SHALL never assert in the same cycle; different channels SHALL be fully independent, including simultaneous presses.
REQ-020 The counter SHALL never wrap, and held keys SHALL produce no repeat pulses.
REQ-021 DEBOUNCE_CYCLES < 1 SHALL be treated as 1.

Reset
REQ-022 Asserting reset SHALL immediately set the synchronizer flops to 1 (released), the FSM to UP, the counter to 0, and key_level, key_press, key_release and key_toggle to 0.
REQ-023 A reset asserted during WAIT_DOWN or WAIT_UP SHALL abort the transition with no pulse emitted.
REQ-024 A key held through reset deassertion SHALL be accepted as a new press after the REQ-018 latency.

Structure
REQ-025 The FSM state encoding typedef and the default DEBOUNCE_CYCLES constant SHALL live in the shared board package.
REQ-026 Each channel SHALL be one instance of sub-module debounce_cell (synchronizer, FSM, counter, pulse/toggle regs); key_debounce SHALL generate NUM_KEYS instances.
REQ-027 Outputs SHALL be suitable for direct connection to the existing LED/seven-segment display logic in place of the raw KEY inputs.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: key_n[0] 1->0 before edge 1 and held -> key_level[0]=1 and key_press[0]=1 at edge 7, key_press[0]=0 at edge 8, key_toggle[0]=1.
REQ-029 Bounce: key_n[0] low for 3 cycles, high 1, then low steady -> no pulse during the bounce; key_press fires 7 edges after the final fall.
REQ-030 Release: from held, key_n[0] -> 1 -> key_release[0] pulse at edge 7, key_level[0]=0, key_toggle[0] stays 1.
REQ-031 Simultaneous: both keys pressed on the same cycle -> key_press=2'b11 on one cycle; a second press of key 1 only -> key_toggle=2'b01.
REQ-032 Reset mid-debounce: reset pulsed while in WAIT_DOWN with count=2 -> all outputs 0 immediately; key still low -> press at edge 7 after release of reset.
REQ-033 Long hold: key held 100 cycles -> exactly one key_press, no counter wrap, key_level stays 1 throughout.
